// File: rtl/seq_addsub_if.sv
// seq_addsub_if: start/done handshake and operand/result bus for seq_addsub.
// The master drives the request and operands; the slave (the adder) drives
// busy/done and the registered result flags.
interface seq_addsub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Cout;
    logic             ovf;

    modport master (
        output start, sub, A, B,
        input  busy, done, D, Cout, ovf
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, D, Cout, ovf
    );
endinterface

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle adder/subtractor. Operands are processed CHUNK bits
// per clock through one CHUNK-wide adder, with the inter-chunk carry held in a
// register. An operation takes N = WIDTH/CHUNK cycles after start is sampled.
//
// Optional build macro SEQ_ADDSUB_SAT_EN: when defined, D saturates to the
// signed limits on overflow (ovf and Cout still report the raw result).
// When undefined, D wraps modulo 2^WIDTH and no saturation logic exists.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last operation
// BUSY  | processing chunk cnt_q; returns to IDLE after chunk N-1
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_addsub_if.slave  bus
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % CHUNK != 0) begin : g_width_chk
        $error("seq_addsub: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sub_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] part_q;

    logic [WIDTH-1:0] d_q;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;

    logic             load;
    logic             step;
    logic             last;
    logic             finish;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] part_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic             ovf_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign last   = (cnt_q == CW'(N - 1));
    assign finish = step & last;

    // Chunk select, chunk add and merge of the new chunk into the partial result
    always_comb begin
        a_chunk  = '0;
        b_chunk  = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
            end
        end

        sum = {1'b0, a_chunk}
            + {1'b0, b_chunk ^ {CHUNK{sub_q}}}
            + {{CHUNK{1'b0}}, carry_q};

        part_nxt = part_q;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                part_nxt[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            end
        end

        // Overflow uses the effective second operand (inverted for subtract).
        ovf_nxt = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q))
               && (part_nxt[WIDTH-1] != a_q[WIDTH-1]);

        d_nxt = part_nxt;
`ifdef SEQ_ADDSUB_SAT_EN
        if (ovf_nxt) begin
            d_nxt = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Operand capture, chunk iteration and result update on the final chunk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            part_q  <= '0;
            d_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (load) begin
                a_q     <= bus.A;
                b_q     <= bus.B;
                sub_q   <= bus.sub;
                carry_q <= bus.sub;
                cnt_q   <= '0;
                part_q  <= '0;
            end else if (step) begin
                part_q  <= part_nxt;
                carry_q <= sum[CHUNK];
                cnt_q   <= finish ? '0 : cnt_q + 1'b1;
                if (finish) begin
                    d_q    <= d_nxt;
                    cout_q <= sum[CHUNK];
                    ovf_q  <= ovf_nxt;
                end
            end
        end
    end

    assign bus.busy = (state_q == BUSY);
    assign bus.done = done_q;
    assign bus.D    = d_q;
    assign bus.Cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: directed self-checking bench for seq_addsub (WIDTH=16, CHUNK=4).
module tb_seq_addsub;

    localparam int W = 16;

`ifdef SEQ_ADDSUB_SAT_EN
    localparam logic [W-1:0] EXP_POS_OVF = 16'h7FFF;
    localparam logic [W-1:0] EXP_NEG_OVF = 16'h8000;
`else
    localparam logic [W-1:0] EXP_POS_OVF = 16'h8000;
    localparam logic [W-1:0] EXP_NEG_OVF = 16'h7FFF;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    seq_addsub_if #(.WIDTH(W)) bus ();

    seq_addsub #(.WIDTH(W), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.sub   = s;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic seen;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.A     = 16'($urandom);
            bus.B     = 16'($urandom);
            bus.sub   = 1'($urandom);
        end
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b exp 0", bus.done); else n_pass++;
        n_checks++; if (bus.D !== 16'h0000) $display("FAIL reset_D got %h exp 0000", bus.D); else n_pass++;
        n_checks++; if ({bus.Cout, bus.ovf} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {bus.Cout, bus.ovf}); else n_pass++;
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        seen      = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL idle_after_reset got activity=%b exp 0", seen); else n_pass++;
    endtask

    task automatic test_sub_basic();
        int e;
        drive_op(16'h0005, 16'h0003, 1'b1);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL sub_busy got %b exp 1", bus.busy); else n_pass++;
        wait_done(e);
        n_checks++; if (e !== 4) $display("FAIL sub_latency got %0d exp 4", e); else n_pass++;
        n_checks++; if (bus.D !== 16'h0002) $display("FAIL sub_D got %h exp 0002", bus.D); else n_pass++;
        n_checks++; if ({bus.Cout, bus.ovf} !== 2'b10) $display("FAIL sub_flags got %b exp 10", {bus.Cout, bus.ovf}); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL sub_idle_in_done got %b exp 0", bus.busy); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL done_pulse_width got %b exp 0", bus.done); else n_pass++;
        n_checks++; if (bus.D !== 16'h0002) $display("FAIL D_hold got %h exp 0002", bus.D); else n_pass++;
    endtask

    task automatic test_borrow_wrap();
        int e;
        drive_op(16'h0003, 16'h0005, 1'b1);
        wait_done(e);
        n_checks++; if (e !== 4) $display("FAIL borrow_latency got %0d exp 4", e); else n_pass++;
        n_checks++; if (bus.D !== 16'hFFFE) $display("FAIL borrow_D got %h exp fffe", bus.D); else n_pass++;
        n_checks++; if ({bus.Cout, bus.ovf} !== 2'b00) $display("FAIL borrow_flags got %b exp 00", {bus.Cout, bus.ovf}); else n_pass++;
        drive_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done(e);
        n_checks++; if (e !== 4) $display("FAIL wrap_latency got %0d exp 4", e); else n_pass++;
        n_checks++; if (bus.D !== 16'h0000) $display("FAIL wrap_D got %h exp 0000", bus.D); else n_pass++;
        n_checks++; if ({bus.Cout, bus.ovf} !== 2'b10) $display("FAIL wrap_flags got %b exp 10", {bus.Cout, bus.ovf}); else n_pass++;
    endtask

    task automatic test_overflow();
        int e;
        drive_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done(e);
        n_checks++; if (e !== 4) $display("FAIL posovf_latency got %0d exp 4", e); else n_pass++;
        n_checks++; if (bus.D !== EXP_POS_OVF) $display("FAIL posovf_D got %h exp %h", bus.D, EXP_POS_OVF); else n_pass++;
        n_checks++; if ({bus.Cout, bus.ovf} !== 2'b01) $display("FAIL posovf_flags got %b exp 01", {bus.Cout, bus.ovf}); else n_pass++;
        drive_op(16'h8000, 16'h0001, 1'b1);
        wait_done(e);
        n_checks++; if (e !== 4) $display("FAIL negovf_latency got %0d exp 4", e); else n_pass++;
        n_checks++; if (bus.D !== EXP_NEG_OVF) $display("FAIL negovf_D got %h exp %h", bus.D, EXP_NEG_OVF); else n_pass++;
        n_checks++; if ({bus.Cout, bus.ovf} !== 2'b11) $display("FAIL negovf_flags got %b exp 11", {bus.Cout, bus.ovf}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e;
        drive_op(16'h1111, 16'h0101, 1'b0);
        // Disturb the request and operands for the whole busy window.
        bus.start = 1'b1;
        bus.A     = 16'hFFFF;
        bus.B     = 16'hFFFF;
        bus.sub   = 1'b1;
        e = -1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 && e < 0) e = i;
        end
        n_checks++; if (e !== 4) $display("FAIL ignore_latency got %0d exp 4", e); else n_pass++;
        n_checks++; if (bus.D !== 16'h1212) $display("FAIL ignore_D got %h exp 1212", bus.D); else n_pass++;
        n_checks++; if ({bus.Cout, bus.ovf} !== 2'b00) $display("FAIL ignore_flags got %b exp 00", {bus.Cout, bus.ovf}); else n_pass++;
        // Start is still high in the done cycle with new operands: accepted.
        bus.A   = 16'h1234;
        bus.B   = 16'h0034;
        bus.sub = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept got busy=%b exp 1", bus.busy); else n_pass++;
        n_checks++; if (bus.D !== 16'h1212) $display("FAIL b2b_D_hold got %h exp 1212", bus.D); else n_pass++;
        wait_done(e);
        n_checks++; if (e !== 4) $display("FAIL b2b_latency got %0d exp 4", e); else n_pass++;
        n_checks++; if (bus.D !== 16'h1200) $display("FAIL b2b_D got %h exp 1200", bus.D); else n_pass++;
        n_checks++; if ({bus.Cout, bus.ovf} !== 2'b10) $display("FAIL b2b_flags got %b exp 10", {bus.Cout, bus.ovf}); else n_pass++;
    endtask

    task automatic test_async_reset();
        int   e;
        logic seen;
        drive_op(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", bus.busy); else n_pass++;
        n_checks++; if (bus.D !== 16'h0000) $display("FAIL abort_D got %h exp 0000", bus.D); else n_pass++;
        n_checks++; if ({bus.done, bus.Cout, bus.ovf} !== 3'b000) $display("FAIL abort_flags got %b exp 000", {bus.done, bus.Cout, bus.ovf}); else n_pass++;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL abort_no_done got activity=%b exp 0", seen); else n_pass++;
        drive_op(16'h00FF, 16'h0001, 1'b0);
        wait_done(e);
        n_checks++; if (e !== 4) $display("FAIL post_reset_latency got %0d exp 4", e); else n_pass++;
        n_checks++; if (bus.D !== 16'h0100) $display("FAIL post_reset_D got %h exp 0100", bus.D); else n_pass++;
        n_checks++; if ({bus.Cout, bus.ovf} !== 2'b00) $display("FAIL post_reset_flags got %b exp 00", {bus.Cout, bus.ovf}); else n_pass++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        test_reset();
        test_sub_basic();
        test_borrow_wrap();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
